// File: rtl/uartp_mem_arbiter.sv
// ============================================================================
// Module   : uartp_mem_arbiter
// Purpose  : Shares one single-port synchronous RAM (1-cycle read latency)
//            between the CPU core (port 0) and the UART host/loader (port 1).
//            At most one access is granted per clock. Contention is settled
//            round-robin, and a port may extend its priority with a bounded
//            lock for multi-word bursts. Read data is returned to the port
//            that issued the read, qualified by an rvalid one cycle after
//            the grant.
// Ports    : clk, rst_n            - clock / synchronous active-low reset
//            mX_req/we/lock        - port X request, write flag, burst lock
//            mX_addr/wdata         - port X address / write data
//            mX_gnt                - port X accepted this cycle (combinational)
//            mX_rvalid/rdata       - port X read return (rdata = ram_q)
//            ram_address/data/wren - RAM control, driven only by this block
//            ram_q                 - RAM read data, valid 1 cycle after address
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uartp_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0 : CPU core
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // port 1 : UART host / loader
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  // Arbitration state
  logic              last;        // port granted most recently
  logic              owner_lock;  // a lock is active
  logic              owner;       // port holding the lock
  logic [HOLD_W-1:0] hold_cnt;    // consecutive lock-extended grants
  logic              rd_pend;     // a read was granted last cycle
  logic              rd_port;     // port that issued that read

  // Grant decode
  logic              gnt_any;
  logic              gnt_port;
  logic              lock_valid;
  logic              gnt_we;
  logic              gnt_lock;
  logic [HOLD_W-1:0] hold_next;

  // Lock priority only counts while the owner has not used up its budget;
  // once saturated, contention falls back to plain round-robin.
  assign lock_valid = owner_lock && (hold_cnt < HOLD_MAX);

  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        gnt_any  = 1'b1;
        gnt_port = lock_valid ? owner : ~last;
      end else if (m0_req) begin
        gnt_any  = 1'b1;
        gnt_port = 1'b0;
      end else if (m1_req) begin
        gnt_any  = 1'b1;
        gnt_port = 1'b1;
      end
    end
  end

  assign m0_gnt   = gnt_any & ~gnt_port;
  assign m1_gnt   = gnt_any &  gnt_port;
  assign gnt_we   = gnt_port ? m1_we   : m0_we;
  assign gnt_lock = gnt_port ? m1_lock : m0_lock;

  // With no grant the RAM bus idles on port 0's address/data, write disabled.
  assign ram_address = m1_gnt ? m1_addr  : m0_addr;
  assign ram_data    = m1_gnt ? m1_wdata : m0_wdata;
  assign ram_wren    = gnt_any & gnt_we;

  // A repeat locked grant to the current owner extends the run (saturating
  // so a lone requester can keep locking forever); any other locked grant
  // starts a fresh run of one.
  always_comb begin
    hold_next = HOLD_ONE;
    if (owner_lock && (owner == gnt_port)) begin
      hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last       <= 1'b1;
      owner_lock <= 1'b0;
      owner      <= 1'b0;
      hold_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_port    <= 1'b0;
    end else begin
      rd_pend <= 1'b0;
      if (gnt_any) begin
        last <= gnt_port;
        if (!gnt_we) begin
          rd_pend <= 1'b1;
          rd_port <= gnt_port;
        end
        if (gnt_lock) begin
          owner_lock <= 1'b1;
          owner      <= gnt_port;
          hold_cnt   <= hold_next;
        end else begin
          owner_lock <= 1'b0;
          hold_cnt   <= '0;
        end
      end
      // No grant: lock state is kept so a pausing owner retains priority.
    end
  end

  // Gating with rst_n suppresses a read return that was in flight when
  // reset was asserted.
  assign m0_rvalid = rst_n & rd_pend & ~rd_port;
  assign m1_rvalid = rst_n & rd_pend &  rd_port;
  assign m0_rdata  = ram_q;
  assign m1_rdata  = ram_q;

endmodule

`default_nettype wire

// File: tb/tb_uartp_mem_arbiter.sv
// ============================================================================
// Module   : tb_uartp_mem_arbiter
// Purpose  : Self-checking bench for uartp_mem_arbiter. A behavioural RAM
//            answers the DUT's RAM port; a reference model of the
//            arbitration rules predicts grants, RAM drive and read returns
//            every cycle. Directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uartp_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  always #5 clk = ~clk;

  uartp_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_lock     (m0_lock),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_lock     (m1_lock),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  // Power-up RAM contents: a fixed pattern with RAM[0x10] = 0xDEADBEEF.
  function automatic logic [DATA_W-1:0] init_val(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'h1000_0000 + DATA_W'(i) * 32'h0001_0003;
  endfunction

  // ---------------- behavioural RAM (write-then-read across edges) ---------
  logic [DATA_W-1:0] ram    [256];
  bit                ram_wr [256];
  always @(posedge clk) begin
    if (ram_wren) begin
      ram[ram_address[7:0]]    <= ram_data;
      ram_wr[ram_address[7:0]] <= 1'b1;
    end
    ram_q <= ram_wr[ram_address[7:0]] ? ram[ram_address[7:0]]
                                      : init_val(int'(ram_address[7:0]));
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // prev winner, burst owner (-1 = none) and its run of locked wins,
  // expected read return for the next cycle, and the expected RAM image.
  int                m_last = 1;
  int                m_owner = -1;
  int                m_run = 0;
  bit                m_pend = 1'b0;
  int                m_pend_port = 0;
  logic [DATA_W-1:0] m_pend_data = '0;
  logic [DATA_W-1:0] mem_m    [256];
  bit                mem_m_wr [256];

  int                e_g;
  logic              e_we, e_lk;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  int                e_idx;

  always @(negedge clk) begin
    // who must win this cycle
    e_g = -1;
    if (rst_n) begin
      if (m0_req && !m1_req)      e_g = 0;
      else if (m1_req && !m0_req) e_g = 1;
      else if (m0_req && m1_req)  e_g = (m_owner >= 0 && m_run < MAX_HOLD) ? m_owner : 1 - m_last;
    end
    e_we   = (e_g == 0) ? m0_we : (e_g == 1) ? m1_we : 1'b0;
    e_lk   = (e_g == 0) ? m0_lock : (e_g == 1) ? m1_lock : 1'b0;
    e_addr = (e_g == 1) ? m1_addr : m0_addr;
    e_data = (e_g == 1) ? m1_wdata : m0_wdata;

    chk("m0_gnt", 64'(m0_gnt), 64'(e_g == 0));
    chk("m1_gnt", 64'(m1_gnt), 64'(e_g == 1));
    chk("ram_wren", 64'(ram_wren), 64'(e_g >= 0 && e_we));
    chk("ram_address", 64'(ram_address), 64'(e_addr));
    chk("ram_data", 64'(ram_data), 64'(e_data));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(rst_n && m_pend && m_pend_port == 0));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(rst_n && m_pend && m_pend_port == 1));
    if (rst_n && m_pend && m_pend_port == 0) chk("m0_rdata", 64'(m0_rdata), 64'(m_pend_data));
    if (rst_n && m_pend && m_pend_port == 1) chk("m1_rdata", 64'(m1_rdata), 64'(m_pend_data));

    // advance model to the state after the coming edge
    if (!rst_n) begin
      m_last  = 1;
      m_owner = -1;
      m_run   = 0;
      m_pend  = 1'b0;
    end else begin
      m_pend = 1'b0;
      if (e_g >= 0) begin
        e_idx = int'(e_addr[7:0]);
        if (e_we) begin
          mem_m[e_idx]    = e_data;
          mem_m_wr[e_idx] = 1'b1;
        end else begin
          m_pend      = 1'b1;
          m_pend_port = e_g;
          m_pend_data = mem_m_wr[e_idx] ? mem_m[e_idx] : init_val(e_idx);
        end
        if (e_lk) begin
          m_run   = (m_owner == e_g) ? ((m_run < MAX_HOLD) ? m_run + 1 : MAX_HOLD) : 1;
          m_owner = e_g;
        end else begin
          m_owner = -1;
          m_run   = 0;
        end
        m_last = e_g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
  endtask

  logic g0, g1;
  int   burst_exp [8] = '{1, 1, 1, 1, 0, 1, 0, 1};

  initial begin
    // --- reset, with a write request that must not reach the RAM
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1234;
    repeat (2) tick();
    mid();
    chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rst_wren", 64'(ram_wren), 64'd0);
    chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    tick();

    // --- m0 reads 0x10
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    mid();
    chk("t1_m0_gnt", 64'(m0_gnt), 64'd1);
    tick();
    idle();
    mid();
    chk("t1_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("t1_m0_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    chk("t1_m1_rvalid", 64'(m1_rvalid), 64'd0);
    tick();

    // --- both read continuously; one m1-only read first so port 0 is next
    m1_req = 1'b1; m1_addr = 32'h41;
    tick();
    m0_req = 1'b1; m0_addr = 32'h30;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("rr_m0_gnt", 64'(m0_gnt), 64'(i % 2 == 0));
      chk("rr_m1_gnt", 64'(m1_gnt), 64'(i % 2 == 1));
      if (i > 0) chk("rr_m0_rvalid", 64'(m0_rvalid), 64'((i - 1) % 2 == 0));
      tick();
    end
    idle();
    mid();
    chk("rr_m1_rvalid_last", 64'(m1_rvalid), 64'd1);
    tick();

    // --- m1 writes 0x5 to 0x20, m0 reads it back next cycle
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h5;
    mid();
    chk("raw_wren_w", 64'(ram_wren), 64'd1);
    tick();
    idle();
    m0_req = 1'b1; m0_addr = 32'h20;
    mid();
    chk("raw_wren_r", 64'(ram_wren), 64'd0);
    chk("raw_m0_gnt", 64'(m0_gnt), 64'd1);
    tick();
    idle();
    mid();
    chk("raw_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("raw_m0_rdata", 64'(m0_rdata), 64'h5);
    tick();

    // --- m1 locked burst against a constant m0 request
    m0_req = 1'b1; m0_addr = 32'h3;
    m1_req = 1'b1; m1_addr = 32'h7;
    for (int i = 0; i < 8; i++) begin
      m1_lock = (i < 4);
      mid();
      chk("burst_m1_gnt", 64'(m1_gnt), 64'(burst_exp[i] == 1));
      chk("burst_m0_gnt", 64'(m0_gnt), 64'(burst_exp[i] == 0));
      tick();
    end
    idle();
    tick();

    // --- reset asserted right after an m0 read grant
    m0_req = 1'b1; m0_addr = 32'h10;
    mid();
    chk("rr_rst_gnt", 64'(m0_gnt), 64'd1);
    tick();
    rst_n = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h11;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rstmid_m0_rvalid", 64'(m0_rvalid), 64'd0);
      chk("rstmid_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
      tick();
    end
    rst_n = 1'b1;
    mid();
    chk("post_rst_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("post_rst_m1_gnt", 64'(m1_gnt), 64'd0);
    tick();
    idle();
    tick();

    // --- lone locked requester keeps winning past MAX_HOLD
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h5;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("solo_m0_gnt", 64'(m0_gnt), 64'd1);
      chk("solo_m1_gnt", 64'(m1_gnt), 64'd0);
      tick();
    end
    idle();
    tick();

    // --- randomized traffic, requests held until granted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      g0 = m0_gnt;
      g1 = m1_gnt;
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 199) != 0);
      if (!m0_req || g0) begin
        m0_req   = ($urandom_range(0, 3) != 0);
        m0_we    = ($urandom_range(0, 2) == 0);
        m0_addr  = ADDR_W'($urandom_range(0, 47));
        m0_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        m0_req = 1'b0;
      end
      if (!m1_req || g1) begin
        m1_req   = ($urandom_range(0, 3) != 0);
        m1_we    = ($urandom_range(0, 2) == 0);
        m1_addr  = ADDR_W'($urandom_range(0, 47));
        m1_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        m1_req = 1'b0;
      end
      m0_lock = ($urandom_range(0, 2) != 0);
      m1_lock = ($urandom_range(0, 2) != 0);
    end

    rst_n = 1'b1;
    idle();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
